// File: rtl/fp_add_align_norm.sv
// fp_add_align_norm: 3-stage FP32 add front end (unpack/compare, align/add, pre-normalize).
// Optional macro FP_ADD_SUB_EN adds the in_op port (1 = compute A - B).
module fp_add_align_norm #(
    parameter int unsigned PIPE_STAGES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
`ifdef FP_ADD_SUB_EN
    input  logic        in_op,
`endif
    input  logic [2:0]  in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [7:0]  out_exp,
    output logic [27:0] out_mant,
    output logic [2:0]  out_rm,
    output logic        out_special,
    output logic [31:0] out_special_val
);

    if (PIPE_STAGES != 3) begin : g_bad_depth
        $error("fp_add_align_norm: PIPE_STAGES must be 3");
    end

    localparam logic [2:0]  RmRdn = 3'b010;
    localparam logic [31:0] QNan  = 32'h7FC0_0000;

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // ---------------- S1: unpack and compare ----------------
    logic        a_sign, b_sign, a_nan, b_nan, a_inf, b_inf, a_ge_b;
    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_frac, b_frac;
    logic [31:0] sval_d;

    assign a_sign = in_a[31];
`ifdef FP_ADD_SUB_EN
    assign b_sign = in_b[31] ^ in_op;
`else
    assign b_sign = in_b[31];
`endif
    assign a_exp  = in_a[30:23];
    assign b_exp  = in_b[30:23];
    // Subnormals are flushed to zero before anything else looks at them.
    assign a_frac = (a_exp == 8'd0) ? 23'd0 : in_a[22:0];
    assign b_frac = (b_exp == 8'd0) ? 23'd0 : in_b[22:0];
    assign a_nan  = (a_exp == 8'hFF) && (in_a[22:0] != 23'd0);
    assign b_nan  = (b_exp == 8'hFF) && (in_b[22:0] != 23'd0);
    assign a_inf  = (a_exp == 8'hFF) && (in_a[22:0] == 23'd0);
    assign b_inf  = (b_exp == 8'hFF) && (in_b[22:0] == 23'd0);
    assign a_ge_b = {a_exp, a_frac} >= {b_exp, b_frac};

    always_comb begin
        sval_d = 32'd0;
        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) sval_d = QNan;
        else if (a_inf) sval_d = {a_sign, 8'hFF, 23'd0};
        else if (b_inf) sval_d = {b_sign, 8'hFF, 23'd0};
    end

    logic        s1_valid, s1_sign, s1_sub, s1_special, s1_zero, s1_zero_sign;
    logic [7:0]  s1_exp, s1_d;
    logic [23:0] s1_man_l, s1_man_s;
    logic [2:0]  s1_rm;
    logic [31:0] s1_sval;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_sign      <= 1'b0;
            s1_exp       <= 8'd0;
            s1_man_l     <= 24'd0;
            s1_man_s     <= 24'd0;
            s1_d         <= 8'd0;
            s1_sub       <= 1'b0;
            s1_rm        <= 3'd0;
            s1_special   <= 1'b0;
            s1_sval      <= 32'd0;
            s1_zero      <= 1'b0;
            s1_zero_sign <= 1'b0;
        end else if (!stall) begin
            s1_valid     <= in_valid;
            s1_sign      <= a_ge_b ? a_sign : b_sign;
            s1_exp       <= a_ge_b ? a_exp : b_exp;
            s1_man_l     <= a_ge_b ? {(a_exp != 8'd0), a_frac} : {(b_exp != 8'd0), b_frac};
            s1_man_s     <= a_ge_b ? {(b_exp != 8'd0), b_frac} : {(a_exp != 8'd0), a_frac};
            s1_d         <= a_ge_b ? a_exp - b_exp : b_exp - a_exp;
            s1_sub       <= a_sign ^ b_sign;
            s1_rm        <= in_rm;
            s1_special   <= a_nan | b_nan | a_inf | b_inf;
            s1_sval      <= sval_d;
            s1_zero      <= (a_exp == 8'd0) && (b_exp == 8'd0);
            s1_zero_sign <= (a_sign & b_sign) | ((a_sign ^ b_sign) & (in_rm == RmRdn));
        end
    end

    // ---------------- S2: align and add ----------------
    logic [26:0] ml, ms, ms_sh;
    logic [27:0] sum_d;

    always_comb begin
        ml = {s1_man_l, 3'b000};
        ms = {s1_man_s, 3'b000};
        if (s1_d >= 8'd27) ms_sh = {26'd0, |ms};
        else ms_sh = (ms >> s1_d) | {26'd0, |(ms & ~(27'h7FF_FFFF << s1_d))};
        sum_d = s1_sub ? ({1'b0, ml} - {1'b0, ms_sh}) : ({1'b0, ml} + {1'b0, ms_sh});
    end

    logic        s2_valid, s2_sign, s2_special, s2_zero, s2_zero_sign;
    logic [7:0]  s2_exp;
    logic [27:0] s2_sum;
    logic [2:0]  s2_rm;
    logic [31:0] s2_sval;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid     <= 1'b0;
            s2_sign      <= 1'b0;
            s2_exp       <= 8'd0;
            s2_sum       <= 28'd0;
            s2_rm        <= 3'd0;
            s2_special   <= 1'b0;
            s2_sval      <= 32'd0;
            s2_zero      <= 1'b0;
            s2_zero_sign <= 1'b0;
        end else if (!stall) begin
            s2_valid     <= s1_valid;
            s2_sign      <= s1_sign;
            s2_exp       <= s1_exp;
            s2_sum       <= sum_d;
            s2_rm        <= s1_rm;
            s2_special   <= s1_special;
            s2_sval      <= s1_sval;
            s2_zero      <= s1_zero;
            s2_zero_sign <= s1_zero_sign;
        end
    end

    // ---------------- S3: normalize ----------------
    logic [4:0]  lzc;
    logic [8:0]  exp_inc;
    logic        n_sign, n_special;
    logic [7:0]  n_exp;
    logic [27:0] n_mant;
    logic [31:0] n_sval;

    always_comb begin
        lzc = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (s2_sum[i]) lzc = 5'(26 - i);
        end
        exp_inc   = {1'b0, s2_exp} + 9'd1;
        n_sign    = s2_sign;
        n_exp     = 8'd0;
        n_mant    = 28'd0;
        n_special = 1'b0;
        n_sval    = 32'd0;
        if (s2_special) begin
            n_sign    = 1'b0;
            n_special = 1'b1;
            n_sval    = s2_sval;
        end else if (s2_zero) begin
            n_sign = s2_zero_sign;
        end else if (s2_sum == 28'd0) begin
            n_sign = (s2_rm == RmRdn);
        end else if (s2_sum[27]) begin
            if (exp_inc >= 9'd255) begin
                n_sign    = 1'b0;
                n_special = 1'b1;
                n_sval    = {s2_sign, 8'hFF, 23'd0};
            end else begin
                n_exp  = exp_inc[7:0];
                n_mant = {1'b0, s2_sum[27:2], s2_sum[1] | s2_sum[0]};
            end
        end else if (s2_exp > {3'd0, lzc}) begin
            n_exp  = s2_exp - {3'd0, lzc};
            n_mant = {1'b0, s2_sum[26:0] << lzc};
        end
        // Remaining case underflows: exp/mant stay zero, sign of L is kept.
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            out_sign        <= 1'b0;
            out_exp         <= 8'd0;
            out_mant        <= 28'd0;
            out_rm          <= 3'd0;
            out_special     <= 1'b0;
            out_special_val <= 32'd0;
        end else if (!stall) begin
            out_valid       <= s2_valid;
            out_sign        <= n_sign;
            out_exp         <= n_exp;
            out_mant        <= n_mant;
            out_rm          <= s2_rm;
            out_special     <= n_special;
            out_special_val <= n_sval;
        end
    end

endmodule
